// File: rtl/motor_host.sv
// motor_host: host master for the motor peripheral tagged write/report pair.
// Ports: cmd_* from CPU, mot_* to peripheral, rep_* from peripheral,
// odo1/odo2 signed odometers, tag_err/timeout_err sticky flags (err_clr).
module motor_host #(
  parameter int TIMEOUT = 1000,
  parameter int ODO_W   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [23:0]             cmd_data,
  input  logic                    odo_clr,
  output logic [3:0]              mot_ctrl,
  output logic [23:0]             mot_data,
  output logic                    mot_wr,
  input  logic [3:0]              rep_ctrl,
  input  logic [23:0]             rep_data,
  input  logic                    rep_wr,
  output logic signed [ODO_W-1:0] odo1,
  output logic signed [ODO_W-1:0] odo2,
  output logic                    tag_err,
  output logic                    timeout_err,
  input  logic                    err_clr
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        tag_q, tag_d;
  logic [3:0]        mot_ctrl_q, mot_ctrl_d;
  logic [23:0]       mot_data_q, mot_data_d;
  logic              mot_wr_q, mot_wr_d;
  logic [1:0]        cur_dir_q, cur_dir_d;
  logic [11:0]       last1_q, last1_d;
  logic [11:0]       last2_q, last2_d;
  logic [ODO_W-1:0]  odo1_q, odo1_d;
  logic [ODO_W-1:0]  odo2_q, odo2_d;
  logic              tag_err_q, tag_err_d;
  logic              to_err_q, to_err_d;
  logic              rep_wr_d_q, rep_wr_d_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;

  logic              is_ovf, is_ack, is_bad, to_hit;
  logic [11:0]       dl1, dl2;
  logic [ODO_W-1:0]  dl1_x, dl2_x;

  always_comb begin
    state_d    = state_q;
    tag_d      = tag_q;
    mot_ctrl_d = mot_ctrl_q;
    mot_data_d = mot_data_q;
    mot_wr_d   = 1'b0;
    cur_dir_d  = cur_dir_q;
    last1_d    = last1_q;
    last2_d    = last2_q;
    odo1_d     = odo1_q;
    odo2_d     = odo2_q;
    wdog_d     = wdog_q;
    rep_wr_d_d = rep_wr;
    to_hit     = 1'b0;

    // Report fields are valid the cycle after rep_wr.
    is_ovf = rep_wr_d_q && (rep_ctrl == 4'hF);
    is_ack = rep_wr_d_q && (state_q == S_WAIT)
             && (rep_ctrl == mot_ctrl_q);
    is_bad = rep_wr_d_q && (state_q == S_WAIT)
             && !is_ovf && !is_ack;

    dl1   = rep_data[11:0] - last1_q;
    dl2   = rep_data[23:12] - last2_q;
    dl1_x = {{(ODO_W-12){1'b0}}, dl1};
    dl2_x = {{(ODO_W-12){1'b0}}, dl2};

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d    = S_ISSUE;
          mot_wr_d   = 1'b1;
          mot_ctrl_d = tag_q;
          mot_data_d = cmd_data;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        wdog_d  = '0;
        tag_d   = (tag_q == 4'd14) ? 4'd0 : tag_q + 4'd1;
      end
      S_WAIT: begin
        wdog_d = wdog_q + 1'b1;
        if (is_ack) begin
          state_d   = S_IDLE;
          cur_dir_d = {mot_data_q[23], mot_data_q[11]};
        end else if (wdog_q == WD_W'(TIMEOUT)) begin
          state_d = S_IDLE;
          to_hit  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Delta uses the direction in force before this report.
    if (is_ovf || is_ack) begin
      odo1_d  = cur_dir_q[0] ? odo1_q + dl1_x : odo1_q - dl1_x;
      odo2_d  = cur_dir_q[1] ? odo2_q + dl2_x : odo2_q - dl2_x;
      // The peripheral zeroes its counters on an accepted write.
      last1_d = is_ack ? 12'd0 : rep_data[11:0];
      last2_d = is_ack ? 12'd0 : rep_data[23:12];
    end

    if (odo_clr) begin
      odo1_d = '0;
      odo2_d = '0;
    end

    tag_err_d = (tag_err_q && !err_clr) || is_bad;
    to_err_d  = (to_err_q && !err_clr) || to_hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tag_q      <= '0;
      mot_ctrl_q <= '0;
      mot_data_q <= '0;
      mot_wr_q   <= 1'b0;
      cur_dir_q  <= '0;
      last1_q    <= '0;
      last2_q    <= '0;
      odo1_q     <= '0;
      odo2_q     <= '0;
      tag_err_q  <= 1'b0;
      to_err_q   <= 1'b0;
      rep_wr_d_q <= 1'b0;
      wdog_q     <= '0;
    end else begin
      state_q    <= state_d;
      tag_q      <= tag_d;
      mot_ctrl_q <= mot_ctrl_d;
      mot_data_q <= mot_data_d;
      mot_wr_q   <= mot_wr_d;
      cur_dir_q  <= cur_dir_d;
      last1_q    <= last1_d;
      last2_q    <= last2_d;
      odo1_q     <= odo1_d;
      odo2_q     <= odo2_d;
      tag_err_q  <= tag_err_d;
      to_err_q   <= to_err_d;
      rep_wr_d_q <= rep_wr_d_d;
      wdog_q     <= wdog_d;
    end
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign mot_ctrl    = mot_ctrl_q;
  assign mot_data    = mot_data_q;
  assign mot_wr      = mot_wr_q;
  assign odo1        = odo1_q;
  assign odo2        = odo2_q;
  assign tag_err     = tag_err_q;
  assign timeout_err = to_err_q;

endmodule

// File: tb/tb_motor_host.sv
// tb_motor_host: directed vector bench for motor_host.
// Drives CPU commands and peripheral reports; checks outputs at negedge.
module tb_motor_host;

  logic               clk = 1'b0;
  logic               rst;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [23:0]        cmd_data;
  logic               odo_clr;
  logic [3:0]         mot_ctrl;
  logic [23:0]        mot_data;
  logic               mot_wr;
  logic [3:0]         rep_ctrl;
  logic [23:0]        rep_data;
  logic               rep_wr;
  logic signed [31:0] odo1;
  logic signed [31:0] odo2;
  logic               tag_err;
  logic               timeout_err;
  logic               err_clr;

  int n_pass = 0;
  int n_total = 0;

  motor_host #(.TIMEOUT(10), .ODO_W(32)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .odo_clr(odo_clr),
    .mot_ctrl(mot_ctrl), .mot_data(mot_data),
    .mot_wr(mot_wr), .rep_ctrl(rep_ctrl),
    .rep_data(rep_data), .rep_wr(rep_wr),
    .odo1(odo1), .odo2(odo2),
    .tag_err(tag_err), .timeout_err(timeout_err),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] cmd;
    logic [23:0] rep;
    logic [31:0] o1;
    logic [31:0] o2;
  } vec_t;

  vec_t vt[5];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  // Full write/ack transaction with a well-behaved peripheral.
  task automatic do_cmd(input logic [23:0] c,
                        input logic [3:0]  t,
                        input logic [23:0] rd,
                        input logic [31:0] e1,
                        input logic [31:0] e2);
    check("ready_pre", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_data  = c;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("mot_wr", 32'(mot_wr), 32'd1);
    check("mot_ctrl", 32'(mot_ctrl), 32'(t));
    check("mot_data", 32'(mot_data), 32'(c));
    rep_wr = 1'b1;
    @(negedge clk);
    rep_wr   = 1'b0;
    rep_ctrl = t;
    rep_data = rd;
    check("wr_pulse", 32'(mot_wr), 32'd0);
    check("busy", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("ready_post", 32'(cmd_ready), 32'd1);
    check("odo1", odo1, e1);
    check("odo2", odo2, e2);
  endtask

  // Single-cycle report request; data follows one cycle later.
  task automatic send_rep(input logic [3:0]  t,
                          input logic [23:0] rd,
                          input logic        clr);
    rep_wr = 1'b1;
    @(negedge clk);
    rep_wr   = 1'b0;
    rep_ctrl = t;
    rep_data = rd;
    odo_clr  = clr;
    @(negedge clk);
    odo_clr = 1'b0;
  endtask

  initial begin
    vt[0] = '{24'h8007FF, 24'h000000, 0, 0};
    vt[1] = '{24'h000800, 24'h064028, -40, 100};
    vt[2] = '{24'h800800, 24'h00700A, -30, 93};
    vt[3] = '{24'h000000, 24'hFFF001, -29, 4188};
    vt[4] = '{24'h800800, 24'h002003, -32, 4186};

    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_data = '0;
    odo_clr = 1'b0;
    rep_ctrl = '0;
    rep_data = '0;
    rep_wr = 1'b0;
    err_clr = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_wr", 32'(mot_wr), 32'd0);
    check("rst_ctrl", 32'(mot_ctrl), 32'd0);
    check("rst_data", 32'(mot_data), 32'd0);
    check("rst_odo1", odo1, 32'd0);
    check("rst_odo2", odo2, 32'd0);
    check("rst_tagerr", 32'(tag_err), 32'd0);
    check("rst_toerr", 32'(timeout_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++)
      do_cmd(vt[i].cmd, 4'(i), vt[i].rep, vt[i].o1, vt[i].o2);

    odo_clr = 1'b1;
    @(negedge clk);
    odo_clr = 1'b0;
    check("clr_odo1", odo1, 32'd0);
    check("clr_odo2", odo2, 32'd0);

    // Held overflow request: only the first sample counts.
    rep_ctrl = 4'hF;
    rep_data = 24'h000FFF;
    rep_wr = 1'b1;
    repeat (20) @(negedge clk);
    rep_wr = 1'b0;
    repeat (2) @(negedge clk);
    check("ovf_odo1", odo1, 32'd4095);
    check("ovf_odo2", odo2, 32'd0);
    check("ovf_idle", 32'(cmd_ready), 32'd1);
    do_cmd(24'h800800, 4'd5, 24'h000005, 32'd4101, 32'd0);

    // Clear coinciding with a delta; last must still move.
    send_rep(4'hF, 24'h000020, 1'b1);
    check("clrdl_odo1", odo1, 32'd0);
    send_rep(4'hF, 24'h000020, 1'b0);
    check("clrdl_rep", odo1, 32'd0);
    send_rep(4'hF, 24'h000030, 1'b0);
    check("ovf16", odo1, 32'd16);

    // Reset in WAIT_ACK.
    cmd_valid = 1'b1;
    cmd_data = 24'hABCDEF;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("wait_busy", 32'(cmd_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("mrst_ready", 32'(cmd_ready), 32'd1);
    check("mrst_wr", 32'(mot_wr), 32'd0);
    check("mrst_ctrl", 32'(mot_ctrl), 32'd0);
    check("mrst_data", 32'(mot_data), 32'd0);
    check("mrst_odo1", odo1, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_retry", 32'(mot_wr), 32'd0);
    end

    for (int i = 0; i < 16; i++)
      do_cmd(24'(i), 4'(i % 15), 24'h0, 32'd0, 32'd0);

    // Wrong tag, with err_clr in the same cycle; then the real ack.
    cmd_valid = 1'b1;
    cmd_data = 24'h000100;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("te_ctrl", 32'(mot_ctrl), 32'd1);
    rep_wr = 1'b1;
    @(negedge clk);
    rep_wr = 1'b0;
    rep_ctrl = 4'd3;
    rep_data = 24'h000010;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("tag_err", 32'(tag_err), 32'd1);
    check("te_busy", 32'(cmd_ready), 32'd0);
    check("te_odo1", odo1, 32'd0);
    send_rep(4'd1, 24'h000000, 1'b0);
    check("te_ack", 32'(cmd_ready), 32'd1);
    check("te_odo1b", odo1, 32'd0);
    check("te_sticky", 32'(tag_err), 32'd1);

    // Silent peripheral.
    cmd_valid = 1'b1;
    cmd_data = 24'h800000;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("to_ctrl", 32'(mot_ctrl), 32'd2);
    repeat (11) @(negedge clk);
    check("to_early", 32'(timeout_err), 32'd0);
    check("to_busy", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("to_err", 32'(timeout_err), 32'd1);
    check("to_idle", 32'(cmd_ready), 32'd1);

    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("eclr_tag", 32'(tag_err), 32'd0);
    check("eclr_to", 32'(timeout_err), 32'd0);

    // Ack lands in the same cycle the watchdog expires.
    cmd_valid = 1'b1;
    cmd_data = 24'h000000;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (10) @(negedge clk);
    send_rep(4'd3, 24'h000000, 1'b0);
    check("aw_to", 32'(timeout_err), 32'd0);
    check("aw_idle", 32'(cmd_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/motor_host.md
# motor_host

Host-side master for the motor peripheral's tagged write/read channel pair. It accepts speed/direction commands from the control CPU and issues them as tagged writes. It waits for each tagged acknowledgement and turns the peripheral's 12-bit per-epoch pulse reports into two signed 32-bit odometers. It sits between the CPU register file and the motor peripheral, one instance per peripheral.

## Interface
- TIMEOUT, 1000: cycles allowed from write issue to matching acknowledgement.
- ODO_W, 32: odometer width in bits; signed two's complement.

- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  CPU command present.
- cmd_ready  out  1  block can accept a command; high only in IDLE.
- cmd_data  in  24  command: bit 23 dir2, bits 22:12 pwm2, bit 11 dir1, bits 10:0 pwm1.
- odo_clr  in  1  synchronous clear of both odometers.
- mot_ctrl  out  4  tag to peripheral.
- mot_data  out  24  command to peripheral; a copy of cmd_data.
- mot_wr  out  1  one-cycle write strobe to peripheral.
- rep_ctrl  in  4  report tag from peripheral; 4'hF means overflow report.
- rep_data  in  24  report counts: bits 23:12 cnt2, bits 11:0 cnt1.
- rep_wr  in  1  report request from peripheral; can stay high for many cycles.
- odo1, odo2  out  ODO_W  signed odometers.
- tag_err  out  1  sticky; a report whose tag is neither the expected tag nor 4'hF arrived in WAIT_ACK.
- timeout_err  out  1  sticky; no acknowledgement arrived within TIMEOUT.
- err_clr  in  1  clears both sticky errors.

## Operation
- States:
  - IDLE: cmd_ready=1. On cmd_valid, latch cmd_data and go to ISSUE.
  - ISSUE: mot_wr=1 for one cycle, mot_ctrl=tag. Go to WAIT_ACK and clear the watchdog.
  - WAIT_ACK: on a matching acknowledgement, go to IDLE. On watchdog==TIMEOUT, set timeout_err and go to IDLE.
- Tag: a 4-bit counter. It advances 0..14 after each ISSUE and then wraps to 0; the value 15 is never issued.
- Report capture:
  - The peripheral registers its report data one cycle after rep_wr.
  - The block registers rep_wr into rep_wr_d. It samples rep_ctrl and rep_data only in cycles where rep_wr_d=1.
- Per-channel delta:
  - delta = (cnt - last) mod 4096, then last <= cnt.
  - Repeated identical reports, such as a held overflow request, therefore add 0.
- Sign: the odometer adds delta if cur_dir bit = 1 and subtracts it if cur_dir bit = 0. cur_dir holds the direction of the command currently applied in the peripheral.
- Acknowledgement (sampled rep_ctrl == issued tag in WAIT_ACK):
  - The delta is applied with the old cur_dir.
  - Then last1 and last2 are set to 0, because the peripheral resets its counters on the write.
  - cur_dir <= the latched command's dir bits.
- Overflow report (tag 4'hF): the delta is applied in any state and the state is unaffected.
- Any other tag in WAIT_ACK: tag_err is set and there is no state change. No delta is applied and last is unchanged.
- Any non-F report in IDLE or ISSUE is ignored.
- Odometer arithmetic is two's complement and wraps silently at ±2^(ODO_W-1).
- Clear priorities:
  - odo_clr together with a delta: the clear wins and the delta is discarded, but last is still updated.
  - err_clr together with a new error: the error wins.

## Timing
- Reset values: cmd_ready=1 (IDLE), mot_wr=0, mot_ctrl=0, mot_data=0, tag=0, cur_dir=0, last1=last2=0, odo1=odo2=0, tag_err=0, timeout_err=0, rep_wr_d=0.
- All outputs are registered except cmd_ready, which is decoded from the state.
- A command accepted at edge N gives mot_wr high during cycle N+1 only. The peripheral raises rep_wr in N+1, and the report is sampled in N+2.
- The odometer update is visible at N+3; cmd_ready is high again at N+3, so the minimum command period is 3 cycles.
- The watchdog starts at 0 in the first WAIT_ACK cycle. timeout_err rises TIMEOUT+1 cycles after mot_wr.
- If an acknowledgement and the timeout occur in the same cycle, the acknowledgement wins.
- Asserting rst mid-WAIT_ACK abandons the transaction; it is not retried after reset.

## Test plan
- Basic write and acknowledgement:
  - Stimulus: reset, then cmd_data=24'h8_00_7FF (dir2=1, pwm1=0x7FF, dir1=0). Model the peripheral acknowledging with report 24'h000_000.
  - Required: mot_wr pulses once with mot_ctrl=0 and mot_data=24'h8007FF, odometers stay 0, cmd_ready returns 3 cycles after acceptance.
- Signed accumulation:
  - Stimulus: with cur_dir=2'b10, the next command's acknowledgement carries cnt2=100 and cnt1=40.
  - Required: odo2=+100 and odo1=-40.
- Held overflow with wrap:
  - Stimulus: rep_ctrl=F and cnt1=0xFFF held for 20 cycles, then an acknowledgement with cnt1=5 (cur_dir bit0=1).
  - Required: odo1=4095 after the overflow and 4101 after the acknowledgement; there is no double count.
- Tag sequencing:
  - Stimulus: issue 16 commands.
  - Required: mot_ctrl sequence is 0..14 followed by 0, and F is never issued.
- Error cases:
  - Stimulus: an acknowledgement with a wrong tag 3; separately, a silent peripheral with TIMEOUT=10.
  - Required: tag_err set; timeout_err set at cycle 11 after mot_wr and the block returns to IDLE; err_clr clears both flags.
- Reset and clear mid-transaction:
  - Stimulus: assert rst in WAIT_ACK; separately, pulse odo_clr in the same cycle as a delta.
  - Required: rst returns all outputs to their reset values immediately. The clear leaves odo=0 with last updated, so a following identical report adds 0.
